// File: rtl/mips_mc_ctrl_if.sv
// ============================================================================
// Module      : mips_mc_ctrl_if
// Description : Controller <-> datapath/memory bundle for the multi-cycle MIPS
//               controller (instruction fields, flags, memory handshake, selects).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_mc_ctrl_if #(
    parameter int OPCODE_WIDTH   = 6,
    parameter int FUNCT_WIDTH    = 6,
    parameter int ALU_CTRL_WIDTH = 3
);
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [FUNCT_WIDTH-1:0]    funct;
    logic                      zero;
    logic                      mem_ready;
    logic                      mem_req;
    logic                      mem_we;
    logic                      iord;
    logic                      ir_write;
    logic                      pc_en;
    logic [1:0]                pc_src;
    logic                      alu_src_a;
    logic [2:0]                alu_src_b;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
    logic                      reg_dst;
    logic                      mem_to_reg;
    logic                      reg_write;
    logic                      illegal;
    logic                      instr_retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write, illegal,
               instr_retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write, illegal,
               instr_retired
    );
endinterface

`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
// ============================================================================
// Module      : mips_mc_ctrl
// Description : Moore main controller for the multi-cycle MIPS datapath with a
//               req/ready memory handshake and explicit illegal-instruction flag.
//               Optional macro MIPS_MC_CTRL_BNE_EN adds bne support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_ctrl #(
    parameter int OPCODE_WIDTH   = 6,
    parameter int FUNCT_WIDTH    = 6,
    parameter int ALU_CTRL_WIDTH = 3
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mips_mc_ctrl_if.master bus
);
    localparam logic [3:0] c_st_reset   = 4'd0;
    localparam logic [3:0] c_st_fetch   = 4'd1;
    localparam logic [3:0] c_st_decode  = 4'd2;
    localparam logic [3:0] c_st_memadr  = 4'd3;
    localparam logic [3:0] c_st_memrd   = 4'd4;
    localparam logic [3:0] c_st_memwb   = 4'd5;
    localparam logic [3:0] c_st_memwr   = 4'd6;
    localparam logic [3:0] c_st_exec    = 4'd7;
    localparam logic [3:0] c_st_aluwb   = 4'd8;
    localparam logic [3:0] c_st_iexec   = 4'd9;
    localparam logic [3:0] c_st_iwb     = 4'd10;
    localparam logic [3:0] c_st_branch  = 4'd11;
    localparam logic [3:0] c_st_jump    = 4'd12;
    localparam logic [3:0] c_st_illegal = 4'd13;

    localparam logic [OPCODE_WIDTH-1:0] c_op_rtype = OPCODE_WIDTH'(6'h00);
    localparam logic [OPCODE_WIDTH-1:0] c_op_j     = OPCODE_WIDTH'(6'h02);
    localparam logic [OPCODE_WIDTH-1:0] c_op_beq   = OPCODE_WIDTH'(6'h04);
    localparam logic [OPCODE_WIDTH-1:0] c_op_bne   = OPCODE_WIDTH'(6'h05);
    localparam logic [OPCODE_WIDTH-1:0] c_op_addi  = OPCODE_WIDTH'(6'h08);
    localparam logic [OPCODE_WIDTH-1:0] c_op_slti  = OPCODE_WIDTH'(6'h0A);
    localparam logic [OPCODE_WIDTH-1:0] c_op_andi  = OPCODE_WIDTH'(6'h0C);
    localparam logic [OPCODE_WIDTH-1:0] c_op_ori   = OPCODE_WIDTH'(6'h0D);
    localparam logic [OPCODE_WIDTH-1:0] c_op_lw    = OPCODE_WIDTH'(6'h23);
    localparam logic [OPCODE_WIDTH-1:0] c_op_sw    = OPCODE_WIDTH'(6'h2B);

    localparam logic [FUNCT_WIDTH-1:0] c_fn_add = FUNCT_WIDTH'(6'h20);
    localparam logic [FUNCT_WIDTH-1:0] c_fn_sub = FUNCT_WIDTH'(6'h22);
    localparam logic [FUNCT_WIDTH-1:0] c_fn_and = FUNCT_WIDTH'(6'h24);
    localparam logic [FUNCT_WIDTH-1:0] c_fn_or  = FUNCT_WIDTH'(6'h25);
    localparam logic [FUNCT_WIDTH-1:0] c_fn_nor = FUNCT_WIDTH'(6'h27);
    localparam logic [FUNCT_WIDTH-1:0] c_fn_slt = FUNCT_WIDTH'(6'h2A);

    localparam logic [ALU_CTRL_WIDTH-1:0] c_alu_add = ALU_CTRL_WIDTH'(0);
    localparam logic [ALU_CTRL_WIDTH-1:0] c_alu_sub = ALU_CTRL_WIDTH'(1);
    localparam logic [ALU_CTRL_WIDTH-1:0] c_alu_and = ALU_CTRL_WIDTH'(2);
    localparam logic [ALU_CTRL_WIDTH-1:0] c_alu_or  = ALU_CTRL_WIDTH'(3);
    localparam logic [ALU_CTRL_WIDTH-1:0] c_alu_slt = ALU_CTRL_WIDTH'(4);
    localparam logic [ALU_CTRL_WIDTH-1:0] c_alu_nor = ALU_CTRL_WIDTH'(5);

    localparam logic [2:0] c_srcb_reg  = 3'd0;
    localparam logic [2:0] c_srcb_four = 3'd1;
    localparam logic [2:0] c_srcb_sext = 3'd2;
    localparam logic [2:0] c_srcb_sxsh = 3'd3;
    localparam logic [2:0] c_srcb_zext = 3'd4;

    logic [3:0]                r_state;
    logic [3:0]                w_next;
    logic                      w_funct_ok;
    logic [ALU_CTRL_WIDTH-1:0] w_funct_alu;

    logic                      w_mem_req;
    logic                      w_mem_we;
    logic                      w_iord;
    logic                      w_ir_write;
    logic                      w_pc_en;
    logic [1:0]                w_pc_src;
    logic                      w_alu_src_a;
    logic [2:0]                w_alu_src_b;
    logic [ALU_CTRL_WIDTH-1:0] w_alu_ctrl;
    logic                      w_reg_dst;
    logic                      w_mem_to_reg;
    logic                      w_reg_write;
    logic                      w_illegal;
    logic                      w_instr_retired;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = c_alu_add;
        case (bus.funct)
            c_fn_add: w_funct_alu = c_alu_add;
            c_fn_sub: w_funct_alu = c_alu_sub;
            c_fn_and: w_funct_alu = c_alu_and;
            c_fn_or:  w_funct_alu = c_alu_or;
            c_fn_nor: w_funct_alu = c_alu_nor;
            c_fn_slt: w_funct_alu = c_alu_slt;
            default:  w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_reset:  w_next = c_st_fetch;
            c_st_fetch:  if (bus.mem_ready) w_next = c_st_decode;
            c_st_decode: begin
                case (bus.opcode)
                    c_op_rtype:                  w_next = c_st_exec;
                    c_op_lw, c_op_sw:            w_next = c_st_memadr;
                    c_op_beq:                    w_next = c_st_branch;
`ifdef MIPS_MC_CTRL_BNE_EN
                    c_op_bne:                    w_next = c_st_branch;
`endif
                    c_op_addi, c_op_slti,
                    c_op_andi, c_op_ori:         w_next = c_st_iexec;
                    c_op_j:                      w_next = c_st_jump;
                    default:                     w_next = c_st_illegal;
                endcase
            end
            c_st_exec:   w_next = w_funct_ok ? c_st_aluwb : c_st_illegal;
            c_st_iexec:  w_next = c_st_iwb;
            c_st_memadr: w_next = (bus.opcode == c_op_sw) ? c_st_memwr : c_st_memrd;
            c_st_memrd:  if (bus.mem_ready) w_next = c_st_memwb;
            c_st_memwr:  if (bus.mem_ready) w_next = c_st_fetch;
            c_st_aluwb, c_st_iwb, c_st_memwb,
            c_st_branch, c_st_jump, c_st_illegal: w_next = c_st_fetch;
            default:     w_next = c_st_reset;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_reset;
        else     r_state <= w_next;
    end

    // Moore decode; mem_ready only qualifies the accept cycle of FETCH/MEMWR,
    // and zero only gates pc_en in BRANCH.
    always_comb begin
        w_mem_req       = 1'b0;
        w_mem_we        = 1'b0;
        w_iord          = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_en         = 1'b0;
        w_pc_src        = 2'd0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = c_srcb_reg;
        w_alu_ctrl      = c_alu_add;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_illegal       = 1'b0;
        w_instr_retired = 1'b0;
        case (r_state)
            c_st_fetch: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = c_srcb_four;
                w_ir_write  = bus.mem_ready;
                w_pc_en     = bus.mem_ready;
            end
            c_st_decode: w_alu_src_b = c_srcb_sxsh;
            c_st_exec: begin
                w_alu_src_a = 1'b1;
                w_alu_ctrl  = w_funct_alu;
            end
            c_st_aluwb: begin
                w_reg_dst       = 1'b1;
                w_reg_write     = 1'b1;
                w_instr_retired = 1'b1;
            end
            c_st_iexec: begin
                w_alu_src_a = 1'b1;
                case (bus.opcode)
                    c_op_addi: w_alu_src_b = c_srcb_sext;
                    c_op_slti: begin
                        w_alu_src_b = c_srcb_sext;
                        w_alu_ctrl  = c_alu_slt;
                    end
                    c_op_andi: begin
                        w_alu_src_b = c_srcb_zext;
                        w_alu_ctrl  = c_alu_and;
                    end
                    c_op_ori: begin
                        w_alu_src_b = c_srcb_zext;
                        w_alu_ctrl  = c_alu_or;
                    end
                    default: w_alu_src_b = c_srcb_sext;
                endcase
            end
            c_st_iwb: begin
                w_reg_write     = 1'b1;
                w_instr_retired = 1'b1;
            end
            c_st_memadr: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = c_srcb_sext;
            end
            c_st_memrd: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            c_st_memwb: begin
                w_mem_to_reg    = 1'b1;
                w_reg_write     = 1'b1;
                w_instr_retired = 1'b1;
            end
            c_st_memwr: begin
                w_mem_req       = 1'b1;
                w_mem_we        = 1'b1;
                w_iord          = 1'b1;
                w_instr_retired = bus.mem_ready;
            end
            c_st_branch: begin
                w_alu_src_a     = 1'b1;
                w_alu_ctrl      = c_alu_sub;
                w_pc_src        = 2'd1;
                w_instr_retired = 1'b1;
`ifdef MIPS_MC_CTRL_BNE_EN
                w_pc_en = (bus.opcode == c_op_bne) ? ~bus.zero : bus.zero;
`else
                w_pc_en = bus.zero;
`endif
            end
            c_st_jump: begin
                w_pc_src        = 2'd2;
                w_pc_en         = 1'b1;
                w_instr_retired = 1'b1;
            end
            c_st_illegal: w_illegal = 1'b1;
            default: ;
        endcase
        // Reset silences the controller immediately, including an in-flight request.
        if (rst) begin
            w_mem_req       = 1'b0;
            w_mem_we        = 1'b0;
            w_iord          = 1'b0;
            w_ir_write      = 1'b0;
            w_pc_en         = 1'b0;
            w_pc_src        = 2'd0;
            w_alu_src_a     = 1'b0;
            w_alu_src_b     = c_srcb_reg;
            w_alu_ctrl      = c_alu_add;
            w_reg_dst       = 1'b0;
            w_mem_to_reg    = 1'b0;
            w_reg_write     = 1'b0;
            w_illegal       = 1'b0;
            w_instr_retired = 1'b0;
        end
    end

    assign bus.mem_req       = w_mem_req;
    assign bus.mem_we        = w_mem_we;
    assign bus.iord          = w_iord;
    assign bus.ir_write      = w_ir_write;
    assign bus.pc_en         = w_pc_en;
    assign bus.pc_src        = w_pc_src;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_ctrl      = w_alu_ctrl;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.reg_write     = w_reg_write;
    assign bus.illegal       = w_illegal;
    assign bus.instr_retired = w_instr_retired;

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
// ============================================================================
// Module      : tb_mips_mc_ctrl
// Description : Self-checking bench for mips_mc_ctrl; a per-instruction model
//               expands each instruction into its expected cycle-by-cycle controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_ctrl;
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
        logic       instr_retired;
    } ctl_t;

    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2,
                           A_OR  = 3'd3, A_SLT = 3'd4, A_NOR = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_mc_ctrl_if bus ();
    mips_mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    ctl_t       exp_q[$];
    logic       rdy_q[$];
    logic       zer_q[$];
    logic [5:0] op_q[$];
    logic [5:0] fn_q[$];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctl_t sample();
        ctl_t s;
        s.mem_req       = bus.mem_req;
        s.mem_we        = bus.mem_we;
        s.iord          = bus.iord;
        s.ir_write      = bus.ir_write;
        s.pc_en         = bus.pc_en;
        s.pc_src        = bus.pc_src;
        s.alu_src_a     = bus.alu_src_a;
        s.alu_src_b     = bus.alu_src_b;
        s.alu_ctrl      = bus.alu_ctrl;
        s.reg_dst       = bus.reg_dst;
        s.mem_to_reg    = bus.mem_to_reg;
        s.reg_write     = bus.reg_write;
        s.illegal       = bus.illegal;
        s.instr_retired = bus.instr_retired;
        return s;
    endfunction

    function automatic ctl_t fetch_wait_vec();
        ctl_t v = '0;
        v.mem_req   = 1'b1;
        v.alu_src_b = 3'd1;
        return v;
    endfunction

    task automatic push(input ctl_t v, input logic r, input logic z,
                        input logic [5:0] op, input logic [5:0] fn);
        exp_q.push_back(v);
        rdy_q.push_back(r);
        zer_q.push_back(z);
        op_q.push_back(op);
        fn_q.push_back(fn);
    endtask

    task automatic clear_q();
        exp_q.delete(); rdy_q.delete(); zer_q.delete(); op_q.delete(); fn_q.delete();
    endtask

    // Expands one instruction (with fw fetch waits and mw data waits) into the
    // controls expected each cycle; mem_ready/zero are randomised wherever ignored.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                               input logic zr, input int fw, input int mw);
        ctl_t v;
        logic [2:0] alu;
        logic ok;
        logic bne_on;
`ifdef MIPS_MC_CTRL_BNE_EN
        bne_on = 1'b1;
`else
        bne_on = 1'b0;
`endif
        for (int i = 0; i < fw; i++) push(fetch_wait_vec(), 1'b0, rb(), op, fn);
        v = fetch_wait_vec(); v.ir_write = 1'b1; v.pc_en = 1'b1;
        push(v, 1'b1, rb(), op, fn);
        v = '0; v.alu_src_b = 3'd3;
        push(v, rb(), rb(), op, fn);
        if (op == 6'h00) begin
            ok = 1'b1;
            case (fn)
                6'h20: alu = A_ADD;
                6'h22: alu = A_SUB;
                6'h24: alu = A_AND;
                6'h25: alu = A_OR;
                6'h27: alu = A_NOR;
                6'h2A: alu = A_SLT;
                default: begin alu = A_ADD; ok = 1'b0; end
            endcase
            v = '0; v.alu_src_a = 1'b1; v.alu_ctrl = alu;
            push(v, rb(), rb(), op, fn);
            v = '0;
            if (ok) begin v.reg_dst = 1'b1; v.reg_write = 1'b1; v.instr_retired = 1'b1; end
            else v.illegal = 1'b1;
            push(v, rb(), rb(), op, fn);
        end else if (op == 6'h23 || op == 6'h2B) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 3'd2;
            push(v, rb(), rb(), op, fn);
            v = '0; v.mem_req = 1'b1; v.iord = 1'b1; v.mem_we = (op == 6'h2B);
            for (int i = 0; i < mw; i++) push(v, 1'b0, rb(), op, fn);
            v.instr_retired = (op == 6'h2B);
            push(v, 1'b1, rb(), op, fn);
            if (op == 6'h23) begin
                v = '0; v.mem_to_reg = 1'b1; v.reg_write = 1'b1; v.instr_retired = 1'b1;
                push(v, rb(), rb(), op, fn);
            end
        end else if (op == 6'h04 || (op == 6'h05 && bne_on)) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_ctrl = A_SUB; v.pc_src = 2'd1;
            v.pc_en = (op == 6'h04) ? zr : ~zr; v.instr_retired = 1'b1;
            push(v, rb(), zr, op, fn);
        end else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D) begin
            v = '0; v.alu_src_a = 1'b1;
            case (op)
                6'h08:   begin v.alu_src_b = 3'd2; v.alu_ctrl = A_ADD; end
                6'h0A:   begin v.alu_src_b = 3'd2; v.alu_ctrl = A_SLT; end
                6'h0C:   begin v.alu_src_b = 3'd4; v.alu_ctrl = A_AND; end
                default: begin v.alu_src_b = 3'd4; v.alu_ctrl = A_OR;  end
            endcase
            push(v, rb(), rb(), op, fn);
            v = '0; v.reg_write = 1'b1; v.instr_retired = 1'b1;
            push(v, rb(), rb(), op, fn);
        end else if (op == 6'h02) begin
            v = '0; v.pc_src = 2'd2; v.pc_en = 1'b1; v.instr_retired = 1'b1;
            push(v, rb(), rb(), op, fn);
        end else begin
            v = '0; v.illegal = 1'b1;
            push(v, rb(), rb(), op, fn);
        end
    endtask

    // Applies one cycle of inputs (entered at posedge+1) and samples at negedge.
    task automatic drive_cycle(input logic r, input logic z, input logic [5:0] op,
                               input logic [5:0] fn, output ctl_t obs);
        bus.mem_ready = r;
        bus.zero      = z;
        bus.opcode    = op;
        bus.funct     = fn;
        @(negedge clk);
        obs = sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ctl_t o;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b1, 6'h23, 6'h20, o);
            checks++;
            if (o !== ctl_t'(0)) begin
                failures++;
                $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, o, ctl_t'(0));
            end
        end
        rst = 1'b0;
        drive_cycle(1'b1, 1'b1, 6'h23, 6'h20, o);
        checks++;
        if (o !== ctl_t'(0)) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", o, ctl_t'(0));
        end
        drive_cycle(1'b0, 1'b0, 6'h00, 6'h20, o);
        checks++;
        if (o !== fetch_wait_vec()) begin
            failures++;
            $display("FAIL reset_to_fetch got=%h exp=%h", o, fetch_wait_vec());
        end
    endtask

    task automatic test_add();
        ctl_t o, e;
        int n = 0, ret_at = -1;
        model_instr(6'h00, 6'h20, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive_cycle(rdy_q.pop_front(), zer_q.pop_front(), op_q.pop_front(), fn_q.pop_front(), o);
            n++;
            if (o.instr_retired === 1'b1 && ret_at < 0) ret_at = n;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL add cyc%0d got=%h exp=%h", n, o, e);
            end
        end
        checks++;
        if (ret_at != 4) begin
            failures++;
            $display("FAIL add_latency got=%0d exp=4", ret_at);
        end
    endtask

    task automatic test_lw_wait();
        ctl_t o, e;
        int n = 0, ret_at = -1;
        model_instr(6'h23, 6'h00, 1'b0, 2, 2);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive_cycle(rdy_q.pop_front(), zer_q.pop_front(), op_q.pop_front(), fn_q.pop_front(), o);
            n++;
            if (o.instr_retired === 1'b1 && ret_at < 0) ret_at = n;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lw_wait cyc%0d got=%h exp=%h", n, o, e);
            end
        end
        checks++;
        if (ret_at != 9) begin
            failures++;
            $display("FAIL lw_latency got=%0d exp=9", ret_at);
        end
    endtask

    task automatic test_beq();
        ctl_t o, e;
        int n = 0, pc_en_seen = 0;
        model_instr(6'h04, 6'h00, 1'b1, 0, 0);
        model_instr(6'h04, 6'h00, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive_cycle(rdy_q.pop_front(), zer_q.pop_front(), op_q.pop_front(), fn_q.pop_front(), o);
            n++;
            if (o.pc_en === 1'b1 && o.pc_src === 2'd1) pc_en_seen++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL beq cyc%0d got=%h exp=%h", n, o, e);
            end
        end
        checks++;
        if (n != 6 || pc_en_seen != 1) begin
            failures++;
            $display("FAIL beq_summary cycles=%0d taken=%0d exp cycles=6 taken=1", n, pc_en_seen);
        end
    endtask

    task automatic test_ori();
        ctl_t o, e;
        int n = 0;
        model_instr(6'h0D, 6'h15, 1'b0, 1, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive_cycle(rdy_q.pop_front(), zer_q.pop_front(), op_q.pop_front(), fn_q.pop_front(), o);
            n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ori cyc%0d got=%h exp=%h", n, o, e);
            end
        end
    endtask

    task automatic test_illegal();
        ctl_t o, e;
        int n = 0, ill = 0, bad = 0;
        model_instr(6'h3F, 6'h20, 1'b0, 0, 0);
        model_instr(6'h00, 6'h01, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive_cycle(rdy_q.pop_front(), zer_q.pop_front(), op_q.pop_front(), fn_q.pop_front(), o);
            n++;
            if (o.illegal === 1'b1) ill++;
            if (o.reg_write === 1'b1 || o.instr_retired === 1'b1 ||
                (o.illegal === 1'b1 && o.mem_req === 1'b1)) bad++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL illegal cyc%0d got=%h exp=%h", n, o, e);
            end
        end
        checks++;
        if (ill != 2 || bad != 0) begin
            failures++;
            $display("FAIL illegal_summary pulses=%0d writes=%0d exp pulses=2 writes=0", ill, bad);
        end
        // The following fetch shows the FSM has returned to FETCH.
        drive_cycle(1'b0, 1'b0, 6'h00, 6'h20, o);
        checks++;
        if (o !== fetch_wait_vec()) begin
            failures++;
            $display("FAIL illegal_return got=%h exp=%h", o, fetch_wait_vec());
        end
    endtask

    task automatic test_reset_during_write();
        ctl_t o, e;
        model_instr(6'h00, 6'h20, 1'b0, 0, 0);
        model_instr(6'h2B, 6'h00, 1'b0, 0, 3);
        while (exp_q.size() != 3) begin
            e = exp_q.pop_front();
            drive_cycle(rdy_q.pop_front(), zer_q.pop_front(), op_q.pop_front(), fn_q.pop_front(), o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sw_pre_reset got=%h exp=%h", o, e);
            end
        end
        clear_q();
        rst = 1'b1;
        drive_cycle(1'b0, 1'b0, 6'h2B, 6'h00, o);
        checks++;
        if (o !== ctl_t'(0)) begin
            failures++;
            $display("FAIL rst_memwr_drop got=%h exp=%h", o, ctl_t'(0));
        end
        rst = 1'b0;
        drive_cycle(1'b1, 1'b1, 6'h2B, 6'h00, o);
        checks++;
        if (o !== ctl_t'(0)) begin
            failures++;
            $display("FAIL rst_release_reset got=%h exp=%h", o, ctl_t'(0));
        end
        drive_cycle(1'b0, 1'b0, 6'h2B, 6'h00, o);
        checks++;
        if (o !== fetch_wait_vec()) begin
            failures++;
            $display("FAIL rst_release_fetch got=%h exp=%h", o, fetch_wait_vec());
        end
    endtask

    task automatic test_bne();
        ctl_t o, e;
        int n = 0;
        model_instr(6'h05, 6'h00, 1'b0, 0, 0);
        model_instr(6'h05, 6'h00, 1'b1, 0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive_cycle(rdy_q.pop_front(), zer_q.pop_front(), op_q.pop_front(), fn_q.pop_front(), o);
            n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bne cyc%0d got=%h exp=%h", n, o, e);
            end
        end
    endtask

    task automatic test_random();
        ctl_t o, e;
        int n = 0;
        logic [5:0] ops[11];
        logic [5:0] fns[7];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 10)];
            fn = fns[$urandom_range(0, 6)];
            if (fn == 6'h00) fn = 6'($urandom);
            model_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive_cycle(rdy_q.pop_front(), zer_q.pop_front(), op_q.pop_front(), fn_q.pop_front(), o);
            n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random cyc%0d got=%h exp=%h", n, o, e);
            end
        end
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_ori();
        test_illegal();
        test_reset_during_write();
        test_bne();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
